// File: rtl/count_ctrl_pkg.sv
// Shared types and constants for the counter enable generator.
package count_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_EVENT = 1'b0;
    localparam logic MODE_TICK  = 1'b1;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a level debouncer; flags the cycle in
// which a new high level is accepted so the top can register the strobe.
module debounce_sync
    import count_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_stable,
    output logic o_rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differs;
    logic             w_settle;

    assign w_differs = (r_sync2 != r_stable);
    assign w_settle  = w_differs && (r_cnt == CNT_LAST);

    // Combinational so the top's enable register lands on the same edge as
    // the stable level it reports.
    assign o_rise   = w_settle && r_sync2;
    assign o_stable = r_stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_settle) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/count_enable_gen.sv
// Run/stop gated enable strobe for the 4-bit up-counter, sourced from either
// a debounced event edge or a programmable prescaler.
module count_enable_gen
    import count_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int PRESCALE_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  event_in,
    output logic                  enable,
    output logic                  active,
    output logic                  evt_stable
);

    state_t                r_state;
    logic                  r_mode_q;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic                  r_enable;
    logic                  r_active;

    state_t w_next;
    logic   w_rise;
    logic   w_run_hold;
    logic   w_mode_chg;
    logic   w_tick_go;
    logic   w_tick_hit;
    logic   w_evt_hit;

    debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_async  (event_in),
        .o_stable (evt_stable),
        .o_rise   (w_rise)
    );

    assign w_next = run ? RUN : IDLE;

    // Both sources only fire while staying in RUN, and a mode switch costs one
    // cycle so the prescaler always restarts from a clean zero.
    assign w_run_hold = (r_state == RUN) && (w_next == RUN);
    assign w_mode_chg = (mode != r_mode_q);
    assign w_tick_go  = w_run_hold && (mode == MODE_TICK) && !w_mode_chg;
    assign w_tick_hit = w_tick_go && (r_pcnt >= prescale);
    assign w_evt_hit  = w_run_hold && (mode == MODE_EVENT) && !w_mode_chg && w_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_mode_q <= MODE_EVENT;
            r_pcnt   <= '0;
            r_enable <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_active <= (w_next == RUN);
            r_mode_q <= mode;
            r_enable <= w_tick_hit || w_evt_hit;
            if (!w_tick_go || w_tick_hit) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + PRESCALE_W'(1);
            end
        end
    end

    assign enable = r_enable;
    assign active = r_active;

endmodule

// File: tb/tb_count_enable_gen.sv
// Directed bench for count_enable_gen: event debounce, glitch rejection,
// prescaler period and retarget, stop and mid-run reset.
module tb_count_enable_gen;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       mode;
    logic [7:0] prescale;
    logic       event_in;
    logic       enable;
    logic       active;
    logic       evt_stable;

    logic [3:0] ctr;
    logic       ctr_clr;

    int vectors;
    int miscompares;

    count_enable_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .mode       (mode),
        .prescale   (prescale),
        .event_in   (event_in),
        .enable     (enable),
        .active     (active),
        .evt_stable (evt_stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the downstream 4-bit counter.
    always @(posedge clk) begin
        if (ctr_clr) ctr <= 4'd0;
        else if (enable) ctr <= ctr + 4'd1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n    = 1'b0;
        run      = 1'b0;
        mode     = 1'b0;
        prescale = 8'd0;
        event_in = 1'b0;
        ctr_clr  = 1'b1;

        tick(3);
        chk("rst_enable", {7'd0, enable}, 8'd0);
        chk("rst_active", {7'd0, active}, 8'd0);
        chk("rst_stable", {7'd0, evt_stable}, 8'd0);
        rst_n   = 1'b1;
        ctr_clr = 1'b0;

        // Stopped: debouncer tracks the input, no strobe.
        event_in = 1'b1;
        tick(5);
        chk("idle_stable_e5", {7'd0, evt_stable}, 8'd0);
        tick(1);
        chk("idle_stable_e6", {7'd0, evt_stable}, 8'd1);
        chk("idle_enable_e6", {7'd0, enable}, 8'd0);
        chk("idle_active", {7'd0, active}, 8'd0);
        event_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("idle_enable_fall", {7'd0, enable}, 8'd0);
        end
        chk("idle_stable_fall", {7'd0, evt_stable}, 8'd0);

        // Event mode rising edge.
        run = 1'b1;
        tick(1);
        chk("evt_active", {7'd0, active}, 8'd1);
        event_in = 1'b1;
        tick(5);
        chk("evt_enable_e5", {7'd0, enable}, 8'd0);
        chk("evt_stable_e5", {7'd0, evt_stable}, 8'd0);
        tick(1);
        chk("evt_enable_e6", {7'd0, enable}, 8'd1);
        chk("evt_stable_e6", {7'd0, evt_stable}, 8'd1);
        tick(1);
        chk("evt_enable_e7", {7'd0, enable}, 8'd0);
        chk("evt_ctr", {4'd0, ctr}, 8'd1);
        event_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("evt_fall_enable", {7'd0, enable}, 8'd0);
        end
        chk("evt_fall_stable", {7'd0, evt_stable}, 8'd0);

        // Three-cycle glitch is rejected.
        event_in = 1'b1;
        tick(3);
        event_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("glitch_stable", {7'd0, evt_stable}, 8'd0);
            chk("glitch_enable", {7'd0, enable}, 8'd0);
        end
        chk("glitch_ctr", {4'd0, ctr}, 8'd1);

        // Tick mode, prescale 3: pulses after e+4, e+8, ... e+20.
        run = 1'b0;
        tick(1);
        chk("stop_active", {7'd0, active}, 8'd0);
        mode     = 1'b1;
        prescale = 8'd3;
        ctr_clr  = 1'b1;
        tick(1);
        ctr_clr = 1'b0;
        run = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            tick(1);
            chk("p3_enable", {7'd0, enable}, (k >= 1 && (k % 4) == 0) ? 8'd1 : 8'd0);
            chk("p3_active", {7'd0, active}, 8'd1);
        end
        run = 1'b0;
        tick(1);
        chk("p3_stop_active", {7'd0, active}, 8'd0);
        chk("p3_stop_enable", {7'd0, enable}, 8'd0);
        chk("p3_ctr", {4'd0, ctr}, 8'd5);

        // Prescale 10 lowered to 2 once the count reaches 7.
        prescale = 8'd10;
        run = 1'b1;
        for (int k = 0; k <= 14; k++) begin
            tick(1);
            chk("retarget_enable", {7'd0, enable},
                (k == 8 || k == 11 || k == 14) ? 8'd1 : 8'd0);
            if (k == 7) prescale = 8'd2;
        end

        // Prescale 0, stop, restart, then reset mid-stream.
        prescale = 8'd0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("p0_enable", {7'd0, enable}, 8'd1);
        end
        run = 1'b0;
        tick(1);
        chk("p0_stop_enable", {7'd0, enable}, 8'd0);
        chk("p0_stop_active", {7'd0, active}, 8'd0);
        run = 1'b1;
        tick(1);
        chk("p0_restart_active", {7'd0, active}, 8'd1);
        chk("p0_restart_enable", {7'd0, enable}, 8'd0);
        tick(1);
        chk("p0_restart_pulse", {7'd0, enable}, 8'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_active", {7'd0, active}, 8'd0);
        chk("midrst_enable", {7'd0, enable}, 8'd0);
        run = 1'b0;
        tick(2);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("postrst_enable", {7'd0, enable}, 8'd0);
            chk("postrst_active", {7'd0, active}, 8'd0);
        end
        run = 1'b1;
        tick(1);
        chk("rerun_active", {7'd0, active}, 8'd1);
        chk("rerun_enable", {7'd0, enable}, 8'd0);
        tick(1);
        chk("rerun_pulse", {7'd0, enable}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
